phy_lane_scheduler: RTL
=======================

# phy_lane_scheduler

Round-robin scheduler that shares the PHY transmit byte path among the four input lanes. Each lane gets a small byte FIFO. The scheduler sequences link bring-up with idle/COM symbols, then grants one buffered byte per cycle to the serializer, tagging each byte with its lane number. It sits between the four `in*_tx`/`valid_in*_tx` sources and the PHY parallel-to-serial stage, and runs entirely in the `clk_4f` domain.

## Interface
- `DEPTH`, default 4: entries per lane FIFO (power of 2, ≥2).
- `SYNC_CYCLES`, default 4: COM symbols sent before entering ACTIVE.
- `COM`, default 8'hBC: idle/alignment symbol.
- `clk_4f`  in  1  only clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  link enable; low forces the link to idle.
- `in0_tx`..`in3_tx`  in  8 each  lane data.
- `valid_in0_tx`..`valid_in3_tx`  in  1 each  lane data valid, one byte per asserted cycle.
- `ready_tx`  in  1  serializer can accept a byte this cycle.
- `out_tx`  out  8  byte to serializer.
- `valid_out_tx`  out  1  `out_tx` is lane data (0 means `out_tx` is COM).
- `lane_out`  out  2  lane id of `out_tx`, valid when `valid_out_tx` is 1.
- `full0`..`full3`  out  1 each  lane FIFO holds DEPTH entries.
- `overflow`  out  4  sticky per-lane drop flags.
- `link_active`  out  1  FSM is in ACTIVE.

## Operation
- **FSM states:** IDLE, SYNC, ACTIVE. Reset value is IDLE.
- **IDLE:** if `enable`=1, go to SYNC on the next edge.
- **SYNC:** emit COM each cycle `ready_tx`=1, decrementing `sync_cnt` (loaded with SYNC_CYCLES on entry). On the last COM, go to ACTIVE. If `enable`=0, return to IDLE.
- **ACTIVE:** if `enable`=0, go to IDLE. FIFO contents are retained.
- **Lane writes:** a lane write happens when `valid_inN_tx`=1 and count<DEPTH (registered count), in any state.
  - If valid_inN_tx=1 while count==DEPTH, the byte is dropped and `overflow[N]` is set.
  - A same-cycle read does not create room for that cycle's write.
- **Grants** happen only in ACTIVE with `ready_tx`=1 and at least one non-empty FIFO.
  - Search order is (last_grant+1) mod 4 upward, wrapping; the first non-empty lane wins.
  - The winner's head is popped and `last_grant` is updated.
  - `last_grant` resets to 3, so lane 0 has first priority.
- **Outputs:**
  - Registered; on a grant the next edge loads `out_tx`=head, `valid_out_tx`=1, `lane_out`=lane.
  - In every other case with `ready_tx`=1: `out_tx`=COM, `valid_out_tx`=0, `lane_out`=0.
  - When `ready_tx`=0, all outputs hold and no pop occurs.
- **FIFO:** circular buffer with wrapping pointers of width log2(DEPTH) and count of width log2(DEPTH)+1. A simultaneous push and pop leaves count unchanged.
- **Overflow:** `overflow` bits clear only on reset.

## Timing
- **Reset values:** `out_tx`=8'hBC, `valid_out_tx`=0, `lane_out`=0, `full*`=0, `overflow`=0, `link_active`=0, all FIFOs empty.
- Reset asserted mid-operation flushes all FIFOs and returns to IDLE on that edge.
- **Bring-up:** with `enable`=1 and `ready_tx`=1, the cycle after reset is IDLE→SYNC, followed by SYNC_CYCLES COM outputs. `link_active`=1 from the following cycle.
- **Latency:** a byte written at edge k into an empty FIFO of an ACTIVE link, with no competing lanes and `ready_tx`=1, appears on `out_tx` after edge k+1.
- **Full flag:** `fullN` is registered and reflects the count after the current edge.
- **Throughput:** sustained 1 byte/cycle total. Four lanes each writing one byte every 4 cycles never overflow.

## Test plan
- **Bring-up:** reset 2 cycles, then `enable`=1, `ready_tx`=1, no data → 4 cycles of `out_tx`=8'hBC with `valid_out_tx`=0, then `link_active`=1, then continued 8'hBC with `valid_out_tx`=0.
- **Fairness:** in ACTIVE, one cycle writing lanes 0-3 with 8'h10, 8'h21, 8'h32, 8'h43 → outputs 10/0, 21/1, 32/2, 43/3 on consecutive cycles.
- **Round-robin wrap and skip:** lane 2 gets 8'hA0, 8'hA1 and lane 0 gets 8'hB0, with `last_grant`=2 → order B0/0, A0/2, A1/2.
- **Overflow:** with `enable`=0, write 5 bytes 01..05 to lane 1 → `full1`=1 after the 4th, `overflow`=4'b0010; after enabling, output is 01..04 only.
- **Backpressure:** `ready_tx` held low 3 cycles mid-stream → `out_tx` holds, no byte lost or duplicated, order preserved.
- **Reset mid-operation:** assert `reset` with 3 bytes queued → next cycle FIFOs are empty, `out_tx`=8'hBC, state IDLE, `overflow`=0.

Source files
------------

// File: rtl/phy_lane_scheduler.sv
// phy_lane_scheduler: four per-lane byte FIFOs feeding one PHY transmit byte
// path. Link bring-up sends COM symbols, then buffered bytes are granted
// round-robin, one per cycle, each tagged with its lane number.
module phy_lane_scheduler #(
    parameter int         DEPTH       = 4,
    parameter int         SYNC_CYCLES = 4,
    parameter logic [7:0] COM         = 8'hBC
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] in0_tx,
    input  logic [7:0] in1_tx,
    input  logic [7:0] in2_tx,
    input  logic [7:0] in3_tx,
    input  logic       valid_in0_tx,
    input  logic       valid_in1_tx,
    input  logic       valid_in2_tx,
    input  logic       valid_in3_tx,
    input  logic       ready_tx,
    output logic [7:0] out_tx,
    output logic       valid_out_tx,
    output logic [1:0] lane_out,
    output logic       full0,
    output logic       full1,
    output logic       full2,
    output logic       full3,
    output logic [3:0] overflow,
    output logic       link_active
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = (SYNC_CYCLES > 0) ? $clog2(SYNC_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Control state
    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_sync_cnt;
    logic [SW-1:0]   w_sync_cnt_nxt;
    logic [1:0]      r_last_grant;

    // Per-lane FIFO storage and bookkeeping
    logic [7:0]      r_mem   [4][DEPTH];
    logic [AW-1:0]   r_wptr  [4];
    logic [AW-1:0]   r_rptr  [4];
    logic [CW-1:0]   r_cnt   [4];
    logic [CW-1:0]   w_cnt_nxt [4];
    logic [3:0]      r_full;
    logic [3:0]      r_ovf;

    // Output registers
    logic [7:0]      r_out_data;
    logic            r_out_vld;
    logic [1:0]      r_out_lane;

    // Lane inputs gathered into arrays
    logic [7:0]      w_in_data [4];
    logic [3:0]      w_in_vld;
    logic [3:0]      w_push;
    logic [3:0]      w_pop;

    // Arbitration
    logic            w_grant;
    logic [1:0]      w_glane;
    logic [1:0]      w_idx;
    logic [7:0]      w_head;

    assign w_in_data[0] = in0_tx;
    assign w_in_data[1] = in1_tx;
    assign w_in_data[2] = in2_tx;
    assign w_in_data[3] = in3_tx;
    assign w_in_vld     = {valid_in3_tx, valid_in2_tx, valid_in1_tx, valid_in0_tx};

    assign w_head = r_mem[w_glane][r_rptr[w_glane]];

    // Link FSM next-state: IDLE -> SYNC (COM burst) -> ACTIVE, enable low aborts
    always_comb begin
        w_state_nxt    = r_state;
        w_sync_cnt_nxt = r_sync_cnt;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt    = ST_SYNC;
                    w_sync_cnt_nxt = SW'(SYNC_CYCLES);
                end
            end
            ST_SYNC: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (ready_tx) begin
                    w_sync_cnt_nxt = r_sync_cnt - SW'(1);
                    if (r_sync_cnt == SW'(1)) begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Round-robin search starting one past the last granted lane
    always_comb begin
        w_grant = 1'b0;
        w_glane = '0;
        w_idx   = '0;
        w_pop   = '0;
        if ((r_state == ST_ACTIVE) && ready_tx) begin
            for (int i = 1; i <= 4; i++) begin
                w_idx = r_last_grant + 2'(i);
                if (!w_grant && (r_cnt[w_idx] != '0)) begin
                    w_grant = 1'b1;
                    w_glane = w_idx;
                end
            end
        end
        w_pop[w_glane] = w_grant;
    end

    // Push qualification uses the registered count, so a same-cycle pop
    // never makes room for a write into a full FIFO
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            w_push[n]    = w_in_vld[n] && (r_cnt[n] != CW'(DEPTH));
            w_cnt_nxt[n] = r_cnt[n] + CW'(w_push[n]) - CW'(w_pop[n]);
        end
    end

    // Control registers: FSM, grant pointer, FIFO pointers/counts, flags
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sync_cnt   <= '0;
            r_last_grant <= 2'd3;
            r_full       <= '0;
            r_ovf        <= '0;
            for (int n = 0; n < 4; n++) begin
                r_wptr[n] <= '0;
                r_rptr[n] <= '0;
                r_cnt[n]  <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
            if (w_grant) begin
                r_last_grant <= w_glane;
            end
            for (int n = 0; n < 4; n++) begin
                if (w_push[n]) begin
                    r_wptr[n] <= r_wptr[n] + AW'(1);
                end
                if (w_pop[n]) begin
                    r_rptr[n] <= r_rptr[n] + AW'(1);
                end
                r_cnt[n]  <= w_cnt_nxt[n];
                r_full[n] <= (w_cnt_nxt[n] == CW'(DEPTH));
                if (w_in_vld[n] && !w_push[n]) begin
                    r_ovf[n] <= 1'b1;
                end
            end
        end
    end

    // FIFO storage write; contents need no reset since counts gate reads
    always_ff @(posedge clk_4f) begin
        for (int n = 0; n < 4; n++) begin
            if (w_push[n]) begin
                r_mem[n][r_wptr[n]] <= w_in_data[n];
            end
        end
    end

    // Output stage: load granted byte or COM when the serializer is ready
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_out_data <= COM;
            r_out_vld  <= 1'b0;
            r_out_lane <= '0;
        end else if (ready_tx) begin
            if (w_grant) begin
                r_out_data <= w_head;
                r_out_vld  <= 1'b1;
                r_out_lane <= w_glane;
            end else begin
                r_out_data <= COM;
                r_out_vld  <= 1'b0;
                r_out_lane <= '0;
            end
        end
    end

    assign out_tx       = r_out_data;
    assign valid_out_tx = r_out_vld;
    assign lane_out     = r_out_lane;
    assign full0        = r_full[0];
    assign full1        = r_full[1];
    assign full2        = r_full[2];
    assign full3        = r_full[3];
    assign overflow     = r_ovf;
    assign link_active  = (r_state == ST_ACTIVE);

endmodule
